// File: rtl/fence_seq_pkg.sv
// fence_seq_pkg: shared state encoding and defaults for the fence sequencer
package fence_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        C_ISSUE,
        C_WAIT,
        T_ISSUE,
        T_WAIT,
        DONE
    } fence_state_t;

    localparam int FENCE_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/fence_done_tracker.sv
// fence_done_tracker: sticky I/D completion flags for one issue/wait phase
module fence_done_tracker (
    input  logic CLK,
    input  logic nRST,
    input  logic issue,
    input  logic wait_en,
    input  logic i_done,
    input  logic d_done,
    output logic both_done
);

    logic i_ok;
    logic d_ok;

    // Issue overwrites stale flags while still catching same-cycle completions
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            i_ok <= 1'b0;
            d_ok <= 1'b0;
        end else if (issue) begin
            i_ok <= i_done;
            d_ok <= d_done;
        end else if (wait_en) begin
            i_ok <= i_ok | i_done;
            d_ok <= d_ok | d_done;
        end
    end

    assign both_done = (i_ok | i_done) & (d_ok | d_done);

endmodule

// File: rtl/fence_sequencer.sv
// fence_sequencer: sequences cache flush and TLB fence pulses for FENCE.I / SFENCE.VMA
// Optional feature macro: ADDRESS_TRANSLATION_EN (TLB phase and operand latching)
module fence_sequencer
    import fence_seq_pkg::*;
#(
    parameter int ASID_W         = 9,
    parameter int TIMEOUT_CYCLES = FENCE_TIMEOUT_DEFAULT
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ifence_req,
    input  logic              sfence_req,
    input  logic [ASID_W-1:0] sfence_asid,
    input  logic [31:0]       sfence_va,
    output logic              icache_flush,
    output logic              dcache_flush,
    input  logic              iflush_done,
    input  logic              dflush_done,
    output logic              itlb_fence,
    output logic              dtlb_fence,
    input  logic              itlb_fence_done,
    input  logic              dtlb_fence_done,
    output logic [ASID_W-1:0] fence_asid,
    output logic [31:0]       fence_va,
    output logic              fence_stall,
    output logic              fence_done,
    output logic              fence_timeout
);

`ifdef ADDRESS_TRANSLATION_EN
    localparam bit TLB_EN = 1'b1;
`else
    localparam bit TLB_EN = 1'b0;
`endif
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    fence_state_t     state;
    logic             s_pend;
    logic [CNT_W-1:0] cnt;
    logic             cache_pulse;
    logic             tlb_pulse;
    logic             c_both;
    logic             t_both;
    logic             tmo;

    assign tmo = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    fence_done_tracker u_cache (
        .CLK       (CLK),
        .nRST      (nRST),
        .issue     (state == C_ISSUE),
        .wait_en   (state == C_WAIT),
        .i_done    (iflush_done),
        .d_done    (dflush_done),
        .both_done (c_both)
    );

`ifdef ADDRESS_TRANSLATION_EN
    fence_done_tracker u_tlb (
        .CLK       (CLK),
        .nRST      (nRST),
        .issue     (state == T_ISSUE),
        .wait_en   (state == T_WAIT),
        .i_done    (itlb_fence_done),
        .d_done    (dtlb_fence_done),
        .both_done (t_both)
    );

    // Operands are captured at acceptance so they stay stable while the pipeline is stalled
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fence_asid <= '0;
            fence_va   <= '0;
        end else if (state == IDLE && (ifence_req || sfence_req)) begin
            fence_asid <= sfence_asid;
            fence_va   <= sfence_va;
        end
    end
`else
    logic unused_tlb;

    assign t_both     = 1'b0;
    assign fence_asid = '0;
    assign fence_va   = '0;
    assign unused_tlb = ^{itlb_fence_done, dtlb_fence_done, sfence_asid, sfence_va};
`endif

    // Sequencer state, registered one-cycle pulses and per-wait timeout counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= IDLE;
            s_pend        <= 1'b0;
            cnt           <= '0;
            cache_pulse   <= 1'b0;
            tlb_pulse     <= 1'b0;
            fence_done    <= 1'b0;
            fence_timeout <= 1'b0;
        end else begin
            cache_pulse   <= 1'b0;
            tlb_pulse     <= 1'b0;
            fence_done    <= 1'b0;
            fence_timeout <= 1'b0;
            cnt           <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    s_pend <= sfence_req;
                    if (ifence_req) begin
                        state       <= C_ISSUE;
                        cache_pulse <= 1'b1;
                    end else if (sfence_req && TLB_EN) begin
                        state     <= T_ISSUE;
                        tlb_pulse <= 1'b1;
                    end else if (sfence_req) begin
                        state      <= DONE;
                        fence_done <= 1'b1;
                    end
                end
                C_ISSUE: begin
                    state <= C_WAIT;
                    cnt   <= '0;
                end
                T_ISSUE: begin
                    state <= T_WAIT;
                    cnt   <= '0;
                end
                C_WAIT: begin
                    if (c_both && s_pend && TLB_EN) begin
                        state     <= T_ISSUE;
                        tlb_pulse <= 1'b1;
                    end else if (c_both || tmo) begin
                        state         <= DONE;
                        fence_done    <= 1'b1;
                        fence_timeout <= !c_both;
                    end
                end
                T_WAIT: begin
                    if (t_both || tmo) begin
                        state         <= DONE;
                        fence_done    <= 1'b1;
                        fence_timeout <= !t_both;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    s_pend <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign icache_flush = cache_pulse;
    assign dcache_flush = cache_pulse;
    assign itlb_fence   = tlb_pulse;
    assign dtlb_fence   = tlb_pulse;
    assign fence_stall  = nRST & (((state != IDLE) && (state != DONE)) ||
                                  ((state == IDLE) && (ifence_req || sfence_req)));

endmodule

// File: tb/tb_fence_sequencer.sv
// tb_fence_sequencer: directed checks of the fence sequencer with TIMEOUT_CYCLES=8
module tb_fence_sequencer;

    logic        CLK;
    logic        nRST;
    logic        ifence_req;
    logic        sfence_req;
    logic [8:0]  sfence_asid;
    logic [31:0] sfence_va;
    logic        icache_flush;
    logic        dcache_flush;
    logic        iflush_done;
    logic        dflush_done;
    logic        itlb_fence;
    logic        dtlb_fence;
    logic        itlb_fence_done;
    logic        dtlb_fence_done;
    logic [8:0]  fence_asid;
    logic [31:0] fence_va;
    logic        fence_stall;
    logic        fence_done;
    logic        fence_timeout;

    int errors = 0;
    int checks = 0;

    fence_sequencer #(.ASID_W(9), .TIMEOUT_CYCLES(8)) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .ifence_req      (ifence_req),
        .sfence_req      (sfence_req),
        .sfence_asid     (sfence_asid),
        .sfence_va       (sfence_va),
        .icache_flush    (icache_flush),
        .dcache_flush    (dcache_flush),
        .iflush_done     (iflush_done),
        .dflush_done     (dflush_done),
        .itlb_fence      (itlb_fence),
        .dtlb_fence      (dtlb_fence),
        .itlb_fence_done (itlb_fence_done),
        .dtlb_fence_done (dtlb_fence_done),
        .fence_asid      (fence_asid),
        .fence_va        (fence_va),
        .fence_stall     (fence_stall),
        .fence_done      (fence_done),
        .fence_timeout   (fence_timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic clear_inputs();
        ifence_req = 0; sfence_req = 0; iflush_done = 0; dflush_done = 0;
        itlb_fence_done = 0; dtlb_fence_done = 0; sfence_asid = '0; sfence_va = '0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] o;
        ifence_req = 1;
        #1;
        o = {icache_flush, dcache_flush, itlb_fence, dtlb_fence, fence_stall, fence_done, fence_timeout};
        checks++;
        if (o !== 7'h0 || fence_asid !== 9'h0 || fence_va !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%b asid=%h va=%h exp=0", o, fence_asid, fence_va);
        end
        ifence_req = 0;
        next_cycle();
        nRST = 1;
        next_cycle();
        checks++;
        if (fence_stall !== 1'b0 || fence_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle stall=%b done=%b exp=0/0", fence_stall, fence_done);
        end
    endtask

    task automatic test_ifence();
        logic [15:0] of = 0, od = 0, os = 0, on = 0, ot = 0;
        for (int c = 0; c < 10; c++) begin
            ifence_req = c < 7; iflush_done = c == 2; dflush_done = c == 6;
            #1;
            of[c] = icache_flush; od[c] = dcache_flush; os[c] = fence_stall; on[c] = fence_done; ot[c] = fence_timeout;
            next_cycle();
        end
        clear_inputs();
        checks++; if (of !== 16'h0002) begin errors++; $display("FAIL ifence_iflush got=%h exp=0002", of); end
        checks++; if (od !== 16'h0002) begin errors++; $display("FAIL ifence_dflush got=%h exp=0002", od); end
        checks++; if (os !== 16'h007F) begin errors++; $display("FAIL ifence_stall got=%h exp=007f", os); end
        checks++; if (on !== 16'h0080) begin errors++; $display("FAIL ifence_done got=%h exp=0080", on); end
        checks++; if (ot !== 16'h0000) begin errors++; $display("FAIL ifence_timeout got=%h exp=0000", ot); end
    endtask

    task automatic test_both_reqs();
`ifdef ADDRESS_TRANSLATION_EN
        localparam int DC = 5;
        localparam logic [15:0] EXP_T = 16'h0008;
`else
        localparam int DC = 3;
        localparam logic [15:0] EXP_T = 16'h0000;
`endif
        logic [15:0] of = 0, ol = 0, os = 0, on = 0;
        logic [15:0] exp_d;
        logic [15:0] exp_s;
        exp_d = 16'h0001 << DC;
        exp_s = exp_d - 16'h0001;
        for (int c = 0; c < 9; c++) begin
            ifence_req = c < DC; sfence_req = c < DC;
            iflush_done = c == 1; dflush_done = c == 1;
            itlb_fence_done = c == 3; dtlb_fence_done = c == 3;
            #1;
            of[c] = icache_flush; ol[c] = itlb_fence & dtlb_fence; os[c] = fence_stall; on[c] = fence_done;
            next_cycle();
        end
        clear_inputs();
        checks++; if (of !== 16'h0002) begin errors++; $display("FAIL both_cache got=%h exp=0002", of); end
        checks++; if (ol !== EXP_T) begin errors++; $display("FAIL both_tlb got=%h exp=%h", ol, EXP_T); end
        checks++; if (on !== exp_d) begin errors++; $display("FAIL both_done got=%h exp=%h", on, exp_d); end
        checks++; if (os !== exp_s) begin errors++; $display("FAIL both_stall got=%h exp=%h", os, exp_s); end
    endtask

`ifdef ADDRESS_TRANSLATION_EN
    task automatic test_operands();
        logic [15:0] ol = 0, on = 0;
        int bad = 0;
        for (int c = 0; c < 6; c++) begin
            sfence_req = c < 3;
            sfence_asid = (c == 0) ? 9'h1A5 : 9'h0F0;
            sfence_va = (c == 0) ? 32'hDEAD_B000 : 32'h1234_5678;
            itlb_fence_done = c == 1; dtlb_fence_done = c == 1;
            #1;
            ol[c] = itlb_fence; on[c] = fence_done;
            if (c >= 1 && c <= 3 && (fence_asid !== 9'h1A5 || fence_va !== 32'hDEAD_B000)) begin
                bad++;
                $display("FAIL operand_hold cycle=%0d asid=%h va=%h exp=1a5/deadb000", c, fence_asid, fence_va);
            end
            next_cycle();
        end
        clear_inputs();
        checks++; if (bad != 0) errors++;
        checks++; if (ol !== 16'h0002) begin errors++; $display("FAIL sfence_itlb got=%h exp=0002", ol); end
        checks++; if (on !== 16'h0008) begin errors++; $display("FAIL sfence_done got=%h exp=0008", on); end
    endtask
`else
    task automatic test_sfence_noat();
        logic [15:0] ol = 0, on = 0, os = 0;
        int bad = 0;
        for (int c = 0; c < 6; c++) begin
            sfence_req = c < 1; sfence_asid = 9'h1A5; sfence_va = 32'hDEAD_B000;
            itlb_fence_done = c == 1; dtlb_fence_done = c == 1;
            #1;
            ol[c] = itlb_fence | dtlb_fence; on[c] = fence_done; os[c] = fence_stall;
            if (fence_asid !== 9'h0 || fence_va !== 32'h0) bad++;
            next_cycle();
        end
        clear_inputs();
        checks++; if (bad != 0) begin errors++; $display("FAIL noat_operands got=%0d nonzero cycles exp=0", bad); end
        checks++; if (ol !== 16'h0000) begin errors++; $display("FAIL noat_tlb got=%h exp=0000", ol); end
        checks++; if (os !== 16'h0001) begin errors++; $display("FAIL noat_stall got=%h exp=0001", os); end
        checks++; if (on !== 16'h0002) begin errors++; $display("FAIL noat_done got=%h exp=0002", on); end
    endtask
`endif

    task automatic test_timeout();
        logic [15:0] of = 0, ol = 0, os = 0, on = 0, ot = 0;
        for (int c = 0; c < 14; c++) begin
            ifence_req = c < 10; sfence_req = c < 10; iflush_done = c == 1;
            #1;
            of[c] = icache_flush; ol[c] = itlb_fence | dtlb_fence; os[c] = fence_stall;
            on[c] = fence_done; ot[c] = fence_timeout;
            next_cycle();
        end
        clear_inputs();
        checks++; if (of !== 16'h0002) begin errors++; $display("FAIL tmo_flush got=%h exp=0002", of); end
        checks++; if (ol !== 16'h0000) begin errors++; $display("FAIL tmo_tlb got=%h exp=0000", ol); end
        checks++; if (os !== 16'h03FF) begin errors++; $display("FAIL tmo_stall got=%h exp=03ff", os); end
        checks++; if (on !== 16'h0400) begin errors++; $display("FAIL tmo_done got=%h exp=0400", on); end
        checks++; if (ot !== 16'h0400) begin errors++; $display("FAIL tmo_flag got=%h exp=0400", ot); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] of = 0, os = 0, on = 0;
        logic [6:0] o;
        for (int c = 0; c < 3; c++) begin
            ifence_req = 1;
            #1;
            of[c] = icache_flush;
            next_cycle();
        end
        checks++; if (of !== 16'h0002) begin errors++; $display("FAIL rstmid_first_flush got=%h exp=0002", of); end
        nRST = 0;
        #1;
        o = {icache_flush, dcache_flush, itlb_fence, dtlb_fence, fence_stall, fence_done, fence_timeout};
        checks++; if (o !== 7'h0) begin errors++; $display("FAIL rstmid_outputs got=%b exp=0000000", o); end
        next_cycle();
        nRST = 1;
        of = 0;
        for (int c = 0; c < 6; c++) begin
            ifence_req = c < 3; iflush_done = c == 1; dflush_done = c == 1;
            #1;
            of[c] = icache_flush; os[c] = fence_stall; on[c] = fence_done;
            next_cycle();
        end
        clear_inputs();
        checks++; if (of !== 16'h0002) begin errors++; $display("FAIL rstmid_reflush got=%h exp=0002", of); end
        checks++; if (os !== 16'h0007) begin errors++; $display("FAIL rstmid_stall got=%h exp=0007", os); end
        checks++; if (on !== 16'h0008) begin errors++; $display("FAIL rstmid_done got=%h exp=0008", on); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] of = 0, os = 0, on = 0;
        for (int c = 0; c < 10; c++) begin
            ifence_req = c < 7; iflush_done = c == 1 || c == 5; dflush_done = c == 1 || c == 5;
            #1;
            of[c] = icache_flush; os[c] = fence_stall; on[c] = fence_done;
            next_cycle();
        end
        clear_inputs();
        checks++; if (of !== 16'h0022) begin errors++; $display("FAIL b2b_flush got=%h exp=0022", of); end
        checks++; if (os !== 16'h0077) begin errors++; $display("FAIL b2b_stall got=%h exp=0077", os); end
        checks++; if (on !== 16'h0088) begin errors++; $display("FAIL b2b_done got=%h exp=0088", on); end
    endtask

    task automatic test_squash_stray();
        logic [15:0] of = 0, os = 0, on = 0;
        for (int c = 0; c < 8; c++) begin
            ifence_req = c == 1 || c == 2; iflush_done = c == 2; dflush_done = c == 0 || c == 4;
            #1;
            of[c] = icache_flush; os[c] = fence_stall; on[c] = fence_done;
            next_cycle();
        end
        clear_inputs();
        checks++; if (of !== 16'h0004) begin errors++; $display("FAIL squash_flush got=%h exp=0004", of); end
        checks++; if (os !== 16'h001E) begin errors++; $display("FAIL squash_stall got=%h exp=001e", os); end
        checks++; if (on !== 16'h0020) begin errors++; $display("FAIL squash_done got=%h exp=0020", on); end
    endtask

    initial begin
        nRST = 0;
        clear_inputs();
        next_cycle();
        test_reset();
        test_ifence();
        test_both_reqs();
`ifdef ADDRESS_TRANSLATION_EN
        test_operands();
`else
        test_sfence_noat();
`endif
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_squash_stray();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fence_sequencer.md
# fence_sequencer

Controller that sequences cache-flush and TLB-fence operations for FENCE.I and SFENCE.VMA instructions held in the memory stage. It issues one-cycle flush/fence pulses to the cache-control interface and tracks the I-side and D-side completions, which may arrive in either order. It stalls the pipeline until every requested operation completes or times out, then retires the fence with a single done pulse. It replaces per-fence ad-hoc pulse/flag logic in the memory stage. The hazard unit consumes `fence_stall`.

## Interface
Parameters:
- `ASID_W`, default 9: width of the SFENCE ASID operand.
- `TIMEOUT_CYCLES`, default 1024: maximum cycles spent in one wait state. A value of 0 disables the timeout.

Ports:
- `CLK`  in  1  clock.
- `nRST`  in  1  reset, asynchronous, active-low.
- `ifence_req`  in  1  FENCE.I is valid in the memory stage. Level signal, held while stalled.
- `sfence_req`  in  1  SFENCE.VMA is valid in the memory stage. Level signal, held while stalled.
- `sfence_asid`  in  ASID_W  rs2 ASID operand.
- `sfence_va`  in  32  rs1 VA operand.
- `icache_flush`, `dcache_flush`  out  1  one-cycle flush pulses.
- `iflush_done`, `dflush_done`  in  1  flush completion pulses.
- `itlb_fence`, `dtlb_fence`  out  1  one-cycle TLB fence pulses.
- `itlb_fence_done`, `dtlb_fence_done`  in  1  TLB fence completion pulses.
- `fence_asid`  out  ASID_W  latched ASID; stable for the whole sequence.
- `fence_va`  out  32  latched VA; stable for the whole sequence.
- `fence_stall`  out  1  stall the pipeline.
- `fence_done`  out  1  one-cycle pulse; the fence instruction may retire.
- `fence_timeout`  out  1  one-cycle pulse coincident with `fence_done` when a wait timed out.

## Operation
- States: IDLE, C_ISSUE, C_WAIT, T_ISSUE, T_WAIT, DONE.
- **IDLE**
  - Samples requests.
  - If `ifence_req`: go to C_ISSUE.
  - Else if `sfence_req`: go to T_ISSUE.
  - On acceptance, latch `ifence_req`/`sfence_req` into pending bits, and latch `sfence_asid`/`sfence_va`.
- **C_ISSUE**
  - `icache_flush` and `dcache_flush` are high for exactly this cycle.
  - Sticky flags `i_ok`/`d_ok` are cleared on entry.
  - Done pulses arriving in C_ISSUE are captured.
  - Go to C_WAIT.
- **C_WAIT**
  - Exit when (`i_ok` or `iflush_done`) and (`d_ok` or `dflush_done`).
  - Exit to T_ISSUE if the sfence bit is pending, otherwise to DONE.
- **T_ISSUE / T_WAIT**
  - Same behaviour as C_ISSUE/C_WAIT, using `itlb_fence`/`dtlb_fence` and `itlb_fence_done`/`dtlb_fence_done`.
  - T_WAIT exits to DONE.
- **DONE**
  - Lasts one cycle.
  - `fence_done`=1, `fence_stall`=0, pending bits cleared.
  - Always returns to IDLE.
  - The pipeline advances in this cycle. A back-to-back fence is accepted in IDLE on the following cycle.
- `fence_stall` = (state not in {IDLE, DONE}) or (state==IDLE and (`ifence_req` or `sfence_req`)). In IDLE this term is combinational.
- Both requests high at once: cache flush first, then TLB fence.
- A request deasserted mid-sequence (squash) does not abort the sequence; it runs to DONE.
- Done pulses received outside the ISSUE/WAIT states are ignored.
- **Timeout**
  - An up-counter, width $clog2(TIMEOUT_CYCLES+1), is cleared on entering each WAIT state.
  - When the counter reaches TIMEOUT_CYCLES-1 without the exit condition, go to DONE with `fence_timeout`=1.
  - Any remaining TLB phase is skipped.

## Timing
- Reset value of all outputs and state: 0 / IDLE.
- Reset mid-sequence: return to IDLE asynchronously. Pulses are not re-issued after reset.
- Minimum latency, FENCE.I with both dones in C_ISSUE:
  - cycle 0: IDLE with request; stall=1.
  - cycle 1: C_ISSUE.
  - cycle 2: C_WAIT.
  - cycle 3: DONE.
  - Stall is high in cycles 0–2.
- Minimum latency for ifence+sfence: DONE at cycle 5.
- Flush/fence pulses are registered state decodes and never exceed one cycle.

## Configuration
- `ADDRESS_TRANSLATION_EN` defined: full behaviour as described above.
- Not defined:
  - T_ISSUE/T_WAIT are unreachable.
  - An sfence-only request goes IDLE→DONE, which is one stall cycle.
  - `itlb_fence`, `dtlb_fence`, `fence_asid` and `fence_va` are tied to 0.
  - The TLB done inputs are ignored.

## Structure
- `fence_seq_pkg`: `fence_state_t` enum and the `FENCE_TIMEOUT_DEFAULT` constant.
- Sub-module `fence_done_tracker`: I/D sticky-flag pair with clear-on-issue, same-cycle capture and a `both_done` output.
  - Instantiated twice: once for the cache phase, once for the TLB phase.

## Test plan
- `ifence_req`=1; `iflush_done` in cycle 2 and `dflush_done` in cycle 6 -> one flush pulse at cycle 1, `fence_done` at cycle 7, stall high in cycles 0–6.
- `ifence_req` and `sfence_req` both high; all dones immediate -> cache pulses at cycle 1, TLB pulses at cycle 3, `fence_done` at cycle 5.
- `sfence_req`, ASID=0x1A5, VA=0xDEAD_B000; inputs change after acceptance -> outputs hold 0x1A5 / 0xDEAD_B000 until DONE.
- TIMEOUT_CYCLES=8, `dflush_done` never arrives -> `fence_done` and `fence_timeout` together, 8 cycles after entering C_WAIT; no TLB pulses.
- `nRST` asserted in C_WAIT -> all outputs 0 immediately. After release with the request still high, a fresh sequence starts with a new pulse.
- Without `ADDRESS_TRANSLATION_EN`, `sfence_req` -> one stall cycle, then `fence_done`; `itlb_fence` stays 0.
